// File: rtl/spi_flash_responder.sv
// spi_flash_responder
// -------------------
// SPI mode-3 slave that stands in for a serial NOR flash. The SPI pins are
// sampled as ordinary data in the clk domain; sck edges are found by comparing
// spi_sck with a registered copy. The design decodes READ (03), PAGE PROGRAM
// (02), READ STATUS (05), JEDEC ID (9F), WRITE ENABLE (06) and WRITE DISABLE
// (04). Every other opcode is ignored until chip select rises. Programming uses
// NOR semantics: a written byte is ANDed into the array, so bits only clear.
//
// Optional feature: define SPI_FLASH_BUSY_EMU_EN to emulate write-in-progress.
// The busy flag is then held for BUSY_CYCLES clk cycles after each program. In
// the default build busy is tied low and no counter is built.
//
// Parameters
//   MEM_AW      byte-address width of the backing array. Must be > 8, because
//               programs wrap inside a 256-byte page.
//   JEDEC_ID    three ID bytes, returned MSB first.
//   BUSY_CYCLES write-in-progress duration in clk cycles (busy build only).
// Ports
//   clk          sole clock
//   reset        synchronous, active-low
//   spi_cs_b     chip select, active low
//   spi_sck      serial clock, idles high, at most clk/2
//   spi_mosi     serial input, MSB first
//   spi_miso     serial output, idles 1
//   spi_miso_oe  high while a response is being shifted out
//   wel          write-enable latch
//   busy         write-in-progress status bit
//   last_cmd     most recently decoded opcode
//   dbg_state_o  current FSM state, for checkers
//
// The array has no reset. The erased state (all 8'hFF) is expected to be
// loaded by the surrounding environment at power-up. Reset leaves the array
// contents unchanged.
module spi_flash_responder #(
    parameter int unsigned MEM_AW      = 10,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int unsigned BUSY_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs_b,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       wel,
    output logic       busy,
    output logic [7:0] last_cmd,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_PROG, S_STAT, S_JEDEC, S_IGNORE
    } state_t;

    state_t              state_q;
    logic                sck_q;
    logic [2:0]          bit_cnt_q;
    logic [6:0]          rx_sr_q;
    logic [7:0]          tx_sr_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [1:0]          addr_cnt_q;
    logic                addr_is_read_q;
    logic [1:0]          id_cnt_q;
    logic                programmed_q;
    logic                miso_q;
    logic                oe_q;
    logic                wel_q;
    logic [7:0]          last_cmd_q;
    logic                busy_now;

    logic [7:0]          mem [0:(1 << MEM_AW) - 1];

`ifdef SPI_FLASH_BUSY_EMU_EN
    localparam int unsigned BCW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    logic                busy_q;
    logic [BCW-1:0]      busy_cnt_q;
    assign busy_now = busy_q;
`else
    assign busy_now = 1'b0;
`endif

    logic              sck_rise;
    logic              sck_fall;
    logic              byte_done;
    logic [7:0]        rx_byte;
    logic [MEM_AW-1:0] addr_shift;
    logic [MEM_AW-1:0] addr_next;
    logic              prog_we;

    assign sck_rise  = !sck_q && spi_sck;
    assign sck_fall  = sck_q && !spi_sck;
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    // The 8th bit is taken straight from the pin so the byte dispatches on the same edge.
    assign rx_byte   = {rx_sr_q, spi_mosi};
    // Shift the address left by one byte. Bits above MEM_AW fall off, which gives address aliasing.
    assign addr_shift = {addr_q[MEM_AW-9:0], rx_byte};
    assign addr_next  = addr_q + MEM_AW'(1);
    // If CS is high on the same edge as the 8th rise, CS wins and nothing is written.
    assign prog_we    = reset && !spi_cs_b && byte_done && (state_q == S_PROG);

    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[addr_q] <= mem[addr_q] & rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            sck_q          <= 1'b1;
            bit_cnt_q      <= 3'd0;
            rx_sr_q        <= 7'd0;
            tx_sr_q        <= 8'hFF;
            addr_q         <= '0;
            addr_cnt_q     <= 2'd0;
            addr_is_read_q <= 1'b0;
            id_cnt_q       <= 2'd0;
            programmed_q   <= 1'b0;
            miso_q         <= 1'b1;
            oe_q           <= 1'b0;
            wel_q          <= 1'b0;
            last_cmd_q     <= 8'h00;
`ifdef SPI_FLASH_BUSY_EMU_EN
            busy_q         <= 1'b0;
            busy_cnt_q     <= '0;
`endif
        end else begin
            sck_q <= spi_sck;
`ifdef SPI_FLASH_BUSY_EMU_EN
            if (busy_q) begin
                if (busy_cnt_q == '0) begin
                    busy_q <= 1'b0;
                end else begin
                    busy_cnt_q <= busy_cnt_q - BCW'(1);
                end
            end
`endif
            if (spi_cs_b) begin
                state_q      <= S_IDLE;
                bit_cnt_q    <= 3'd0;
                miso_q       <= 1'b1;
                oe_q         <= 1'b0;
                programmed_q <= 1'b0;
                // A program commits when CS rises.
                if (programmed_q) begin
                    wel_q <= 1'b0;
`ifdef SPI_FLASH_BUSY_EMU_EN
                    busy_q     <= 1'b1;
                    busy_cnt_q <= BCW'(BUSY_CYCLES - 1);
`endif
                end
            end else begin
                if (sck_fall) begin
                    miso_q  <= tx_sr_q[7];
                    tx_sr_q <= {tx_sr_q[6:0], 1'b1};
                    oe_q    <= (state_q == S_READ) || (state_q == S_STAT) ||
                               (state_q == S_JEDEC);
                end
                if (sck_rise) begin
                    rx_sr_q   <= {rx_sr_q[5:0], spi_mosi};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (state_q == S_IDLE) begin
                    state_q <= S_CMD;
                end else if (byte_done) begin
                    case (state_q)
                        S_CMD: begin
                            last_cmd_q <= rx_byte;
                            case (rx_byte)
                                8'h03: begin
                                    state_q        <= busy_now ? S_IGNORE : S_ADDR;
                                    addr_is_read_q <= 1'b1;
                                    addr_cnt_q     <= 2'd0;
                                end
                                8'h02: begin
                                    state_q        <= (wel_q && !busy_now) ? S_ADDR : S_IGNORE;
                                    addr_is_read_q <= 1'b0;
                                    addr_cnt_q     <= 2'd0;
                                end
                                8'h05: begin
                                    state_q <= S_STAT;
                                    tx_sr_q <= {6'b0, wel_q, busy_now};
                                end
                                8'h9F: begin
                                    state_q  <= S_JEDEC;
                                    tx_sr_q  <= JEDEC_ID[23:16];
                                    id_cnt_q <= 2'd1;
                                end
                                8'h06: begin
                                    wel_q   <= 1'b1;
                                    state_q <= S_IGNORE;
                                end
                                8'h04: begin
                                    wel_q   <= 1'b0;
                                    state_q <= S_IGNORE;
                                end
                                default: state_q <= S_IGNORE;
                            endcase
                        end
                        S_ADDR: begin
                            addr_q     <= addr_shift;
                            addr_cnt_q <= addr_cnt_q + 2'd1;
                            if (addr_cnt_q == 2'd2) begin
                                if (addr_is_read_q) begin
                                    state_q <= S_READ;
                                    // The first data byte is ready with no dummy byte.
                                    tx_sr_q <= mem[addr_shift];
                                end else begin
                                    state_q <= S_PROG;
                                end
                            end
                        end
                        S_READ: begin
                            addr_q  <= addr_next;
                            tx_sr_q <= mem[addr_next];
                        end
                        S_PROG: begin
                            // Keep the page bits and wrap the byte offset.
                            addr_q       <= {addr_q[MEM_AW-1:8], addr_q[7:0] + 8'd1};
                            programmed_q <= 1'b1;
                        end
                        S_STAT: begin
                            tx_sr_q <= {6'b0, wel_q, busy_now};
                        end
                        S_JEDEC: begin
                            case (id_cnt_q)
                                2'd1:    tx_sr_q <= JEDEC_ID[15:8];
                                2'd2:    tx_sr_q <= JEDEC_ID[7:0];
                                default: tx_sr_q <= 8'hFF;
                            endcase
                            if (id_cnt_q != 2'd3) begin
                                id_cnt_q <= id_cnt_q + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign wel         = wel_q;
    assign busy        = busy_now;
    assign last_cmd    = last_cmd_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Testbench for spi_flash_responder. A mode-3 SPI master drives transactions.
// A transaction-level flash model predicts the pin behaviour: a byte array,
// the wel bit, a busy window measured in clk cycles, and per-transaction byte
// indices. A compare process checks the DUT against the model on every
// negedge. Literal expectations from the directed scenarios pin the model.
module tb_spi_flash_responder;
    localparam int          AW     = 10;
    localparam int          DEPTH  = 1 << AW;
    localparam int          BUSY_N = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_cs_b;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       wel;
    logic       busy;
    logic [7:0] last_cmd;
    logic [2:0] dbg_state;

    spi_flash_responder #(
        .MEM_AW(AW), .JEDEC_ID(24'hEF4016), .BUSY_CYCLES(BUSY_N)
    ) dut (
        .clk(clk), .reset(reset), .spi_cs_b(spi_cs_b), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wel(wel), .busy(busy), .last_cmd(last_cmd), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard counters ----------------
    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mem_m [DEPTH];
    logic [23:0] id_v       = 24'hEF4016;
    logic        wel_m      = 1'b0;
    logic [7:0]  last_cmd_m = 8'h00;
    logic        exp_oe     = 1'b0;
    logic        exp_miso   = 1'b1;
    logic        idle_m     = 1'b1;
    logic        chk_on     = 1'b0;
    int          busy_start = -100000;
    int          tr_idx;
    logic [7:0]  tr_op;
    logic        tr_ok, tr_resp, tr_prog;
    int          tr_addr;
    logic [7:0]  out_byte;

    // Busy as seen just after the posedge numbered c.
    function automatic logic busy_at(input int c);
`ifdef SPI_FLASH_BUSY_EMU_EN
        return (c >= busy_start) && (c < busy_start + BUSY_N);
`else
        return (c < 0) && (busy_start > 0);
`endif
    endfunction

    // Apply one completed byte d to the model. This is called just after the clk edge that saw the 8th rise.
    task automatic model_byte(input logic [7:0] d);
        logic b;
        b = busy_at(cyc - 1);
        if (tr_idx == 0) begin
            last_cmd_m = d;
            tr_op      = d;
            case (d)
                8'h03: tr_ok = !b;
                8'h02: tr_ok = wel_m && !b;
                8'h05: begin tr_resp = 1'b1; out_byte = {6'b0, wel_m, b}; end
                8'h9F: begin tr_resp = 1'b1; out_byte = id_v[23:16]; end
                8'h06: wel_m = 1'b1;
                8'h04: wel_m = 1'b0;
                default: ;
            endcase
        end else if (tr_ok) begin
            if (tr_idx <= 3) begin
                tr_addr = ((tr_addr * 256) + int'(d)) % DEPTH;
                if (tr_idx == 3 && tr_op == 8'h03) begin
                    tr_resp  = 1'b1;
                    out_byte = mem_m[tr_addr];
                end
            end else if (tr_op == 8'h03) begin
                tr_addr  = (tr_addr + 1) % DEPTH;
                out_byte = mem_m[tr_addr];
            end else begin
                mem_m[tr_addr] = mem_m[tr_addr] & d;
                tr_addr = (tr_addr / 256) * 256 + (tr_addr + 1) % 256;
                tr_prog = 1'b1;
            end
        end else if (tr_op == 8'h05) begin
            out_byte = {6'b0, wel_m, b};
        end else if (tr_op == 8'h9F) begin
            out_byte = (tr_idx == 1) ? id_v[15:8] : (tr_idx == 2) ? id_v[7:0] : 8'hFF;
        end
        tr_idx++;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("wel", wel, wel_m);
            chk("busy", busy, busy_at(cyc));
            chk("last_cmd", last_cmd, last_cmd_m);
            chk("miso_oe", spi_miso_oe, exp_oe);
            if (exp_oe || idle_m) chk("miso", spi_miso, exp_miso);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        dut.mem[a] = v;
        mem_m[a]   = v;
    endtask

    task automatic cs_low();
        spi_cs_b = 1'b0;
        tick();
        tr_idx = 0; tr_op = 8'h00; tr_ok = 1'b0; tr_resp = 1'b0;
        tr_prog = 1'b0; tr_addr = 0; idle_m = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic cs_high();
        tick();
        spi_cs_b = 1'b1;
        tick();
        exp_oe = 1'b0; exp_miso = 1'b1; idle_m = 1'b1;
        if (tr_prog) begin
            wel_m      = 1'b0;
            busy_start = cyc;
        end
        repeat (2) tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input int nbits,
                             output logic [7:0] got, output logic was_resp,
                             output logic [7:0] want);
        int h;
        got      = 8'h00;
        was_resp = tr_resp;
        want     = out_byte;
        for (int i = 0; i < nbits; i++) begin
            h = $urandom_range(1, 3);
            spi_sck  = 1'b0;
            spi_mosi = d[7-i];
            tick();
            exp_oe   = was_resp;
            exp_miso = want[7-i];
            repeat (h - 1) tick();
            got[7-i] = spi_miso;
            h = $urandom_range(1, 3);
            spi_sck = 1'b1;
            tick();
            if (i == 7) model_byte(d);
            repeat (h - 1) tick();
        end
    endtask

    task automatic xfer(input logic [7:0] tx [$], input int last_bits, output logic [7:0] rx [$]);
        logic [7:0] g, w;
        logic       r;
        int         nb;
        rx = {};
        cs_low();
        for (int k = 0; k < tx.size(); k++) begin
            nb = (k == tx.size() - 1) ? last_bits : 8;
            send_byte(tx[k], nb, g, r, w);
            if (nb == 8) begin
                rx.push_back(g);
                if (r) chk("miso_byte", g, w);
            end
        end
        cs_high();
    endtask

    task automatic settle();
`ifdef SPI_FLASH_BUSY_EMU_EN
        repeat (BUSY_N + 8) tick();
`else
        tick();
`endif
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] rx [$];
    logic [7:0] txq [$];

    initial begin
        reset = 1'b0; spi_cs_b = 1'b1; spi_sck = 1'b1; spi_mosi = 1'b0;
        for (int i = 0; i < DEPTH; i++) poke(i, 8'hFF);
        repeat (3) tick();
        chk_on = 1'b1;
        chk("rst_miso", spi_miso, 1'b1);
        chk("rst_oe", spi_miso_oe, 1'b0);
        chk("rst_wel", wel, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_last_cmd", last_cmd, 8'h00);
        reset = 1'b1;
        repeat (2) tick();

        // JEDEC ID, then FF
        xfer('{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00}, 8, rx);
        chk("jedec_b0", rx[1], 8'hEF);
        chk("jedec_b1", rx[2], 8'h40);
        chk("jedec_b2", rx[3], 8'h16);
        chk("jedec_b3", rx[4], 8'hFF);
        chk("jedec_last_cmd", last_cmd, 8'h9F);

        // Read wraps from the top of the array to address 0; upper address bits alias
        poke(10'h3FF, 8'hA5);
        poke(0, 8'h5A);
        xfer('{8'h03, 8'h00, 8'h03, 8'hFF, 8'h00, 8'h00}, 8, rx);
        chk("read_wrap_0", rx[4], 8'hA5);
        chk("read_wrap_1", rx[5], 8'h5A);

        // Program ANDs the byte into the array
        poke(10'h010, 8'hF0);
        xfer('{8'h06}, 8, rx);
        chk("wel_set", wel, 1'b1);
        xfer('{8'h02, 8'h00, 8'h00, 8'h10, 8'h3C}, 8, rx);
        chk("wel_after_prog", wel, 1'b0);
        settle();
        xfer('{8'h03, 8'h00, 8'h00, 8'h10, 8'h00}, 8, rx);
        chk("prog_and", rx[4], 8'h30);

        // Program without write enable has no effect
        poke(10'h020, 8'h0F);
        xfer('{8'h02, 8'h00, 8'h00, 8'h20, 8'h00}, 8, rx);
        xfer('{8'h03, 8'h00, 8'h00, 8'h20, 8'h00}, 8, rx);
        chk("prog_no_wel", rx[4], 8'h0F);

        // Page wrap
        poke(10'h0FE, 8'hFF); poke(10'h0FF, 8'hFF); poke(0, 8'hFF); poke(10'h100, 8'hFF);
        xfer('{8'h06}, 8, rx);
        xfer('{8'h02, 8'h00, 8'h00, 8'hFE, 8'hAA, 8'hBB, 8'hCC}, 8, rx);
        settle();
        xfer('{8'h03, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00}, 8, rx);
        chk("page_fe", rx[4], 8'hAA);
        chk("page_ff", rx[5], 8'hBB);
        chk("page_100", rx[6], 8'hFF);
        xfer('{8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 8, rx);
        chk("page_000", rx[4], 8'hCC);

        // Abort after 5 bits of an opcode
        xfer('{8'h03}, 5, rx);
        xfer('{8'h05, 8'h00}, 8, rx);
        chk("abort_stat", rx[1], 8'h00);
        xfer('{8'h06}, 8, rx);
        xfer('{8'h03}, 5, rx);
        xfer('{8'h05, 8'h00}, 8, rx);
        chk("abort_stat_wel", rx[1], 8'h02);

        // Reset mid-transaction: outputs return to reset values, array is kept
        cs_low();
        begin
            logic [7:0] g, w; logic r;
            send_byte(8'h9F, 8, g, r, w);
            send_byte(8'h00, 3, g, r, w);
        end
        reset = 1'b0;
        tick();
        wel_m = 1'b0; last_cmd_m = 8'h00; exp_oe = 1'b0; exp_miso = 1'b1;
        idle_m = 1'b1; busy_start = -100000;
        chk("midrst_oe", spi_miso_oe, 1'b0);
        chk("midrst_wel", wel, 1'b0);
        chk("midrst_last_cmd", last_cmd, 8'h00);
        chk("midrst_miso", spi_miso, 1'b1);
        spi_sck = 1'b1; spi_cs_b = 1'b1;
        tick();
        reset = 1'b1;
        repeat (2) tick();
        xfer('{8'h03, 8'h00, 8'h00, 8'h10, 8'h00}, 8, rx);
        chk("midrst_mem_kept", rx[4], 8'h30);

`ifdef SPI_FLASH_BUSY_EMU_EN
        // Busy window after a program
        begin
            int polls;
            xfer('{8'h06}, 8, rx);
            xfer('{8'h02, 8'h00, 8'h00, 8'h40, 8'h55}, 8, rx);
            xfer('{8'h05, 8'h00}, 8, rx);
            chk("busy_stat", rx[1], 8'h01);
            xfer('{8'h03, 8'h00, 8'h00, 8'h40, 8'h00}, 8, rx);
            polls = 0;
            while (busy_at(cyc) && polls < 20) begin
                xfer('{8'h05, 8'h00}, 8, rx);
                polls++;
            end
            chk("busy_timeout", busy_at(cyc), 1'b0);
            xfer('{8'h05, 8'h00}, 8, rx);
            chk("busy_done_stat", rx[1], 8'h00);
        end
`endif

        // Randomized transactions
        for (int t = 0; t < 70; t++) begin
            logic [7:0] op;
            int a, nd, lb;
            case ($urandom_range(0, 7))
                0, 7:    op = 8'h03;
                1:       op = 8'h02;
                2:       op = 8'h05;
                3:       op = 8'h9F;
                4:       op = 8'h06;
                5:       op = 8'h04;
                default: op = 8'($urandom_range(0, 255));
            endcase
            a  = $urandom_range(0, 4095) * 4096 + $urandom_range(0, 1023);
            nd = $urandom_range(0, 5);
            txq = {};
            txq.push_back(op);
            if (op == 8'h03 || op == 8'h02) begin
                txq.push_back(8'(a / 65536));
                txq.push_back(8'(a / 256));
                txq.push_back(8'(a));
            end
            for (int k = 0; k < nd; k++) txq.push_back(8'($urandom_range(0, 255)));
            lb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
            xfer(txq, lb, rx);
        end

        repeat (4) tick();
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
